// File: rtl/rv32_alu_arb_if.sv
// Shared ALU types and the requester/response bundle of rv32_alu_arb.
// The arbiter sits on the slave side; requesters and the result consumer use the master side.
package rv32_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

endpackage

interface rv32_alu_arb_if #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  rv32_pkg::alu_op_e     req_op [NREQ];
  logic [NREQ-1:0][31:0] req_a;
  logic [NREQ-1:0][31:0] req_b;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [31:0]           rsp_y;
  rv32_pkg::alu_op_e     rsp_op;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_op
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_y, rsp_op
  );

endinterface

// File: rtl/rv32_alu_arb.sv
// One RV32 ALU shared by NREQ requesters through a round-robin arbiter,
// with a single registered result slot that supports drain-and-refill every cycle.
module rv32_alu
  import rv32_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic [4:0] shamt;

  assign shamt = b[4:0];

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'b0, a < b};
      ALU_SLL:  y = a << shamt;
      ALU_SRL:  y = a >> shamt;
      ALU_SRA:  y = $unsigned($signed(a) >>> shamt);
      default:  y = '0;
    endcase
  end

endmodule

module rv32_alu_arb
  import rv32_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input logic            clk,
  input logic            rst,
  rv32_alu_arb_if.slave  bus
);

  localparam int SW = IDW + 1;

  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  ptr_nxt;
  logic [IDW-1:0]  win;
  logic [IDW-1:0]  idx;
  logic [SW-1:0]   sum;
  logic            any_valid;
  logic            can_accept;
  logic            hs;
  logic [NREQ-1:0] grant;

  alu_op_e         alu_op;
  logic [31:0]     alu_a;
  logic [31:0]     alu_b;
  logic [31:0]     alu_y;

  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [31:0]     rsp_y_q;
  alu_op_e         rsp_op_q;

  assign can_accept = !rsp_valid_q || bus.rsp_ready;

  // First valid requester found scanning upward from ptr, wrapping at NREQ.
  always_comb begin
    any_valid = 1'b0;
    win       = '0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + SW'(k);
      if (sum >= SW'(NREQ)) begin
        sum = sum - SW'(NREQ);
      end
      idx = sum[IDW-1:0];
      if (!any_valid && bus.req_valid[idx]) begin
        any_valid = 1'b1;
        win       = idx;
      end
    end
  end

  assign hs = any_valid && can_accept && !rst;

  always_comb begin
    grant = '0;
    if (hs) begin
      grant[win] = 1'b1;
    end
  end

  assign bus.req_ready = grant;

  assign ptr_nxt = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);

  assign alu_op = bus.req_op[win];
  assign alu_a  = bus.req_a[win];
  assign alu_b  = bus.req_b[win];

  rv32_alu u_alu (
    .op (alu_op),
    .a  (alu_a),
    .b  (alu_b),
    .y  (alu_y)
  );

  // Priority only rotates on an actual transfer; data fields hold once drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_y_q     <= '0;
      rsp_op_q    <= ALU_ADD;
    end else if (hs) begin
      ptr         <= ptr_nxt;
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= win;
      rsp_y_q     <= alu_y;
      rsp_op_q    <= alu_op;
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_op    = rsp_op_q;

endmodule

// File: tb/tb_rv32_alu_arb.sv
// Scoreboard bench for rv32_alu_arb: a 2-requester and a 3-requester instance,
// directed scenarios followed by constrained-random traffic against a reference model.
module tb_rv32_alu_arb;
  import rv32_pkg::*;

  typedef struct {
    int          id;
    alu_op_e     op;
    logic [31:0] y;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  rv32_alu_arb_if #(.NREQ(2)) if2 ();
  rv32_alu_arb_if #(.NREQ(3)) if3 ();

  rv32_alu_arb #(.NREQ(2)) u2 (.clk(clk), .rst(rst), .bus(if2));
  rv32_alu_arb #(.NREQ(3)) u3 (.clk(clk), .rst(rst), .bus(if3));

  // Driven values (index 0 -> 2-requester DUT, 1 -> 3-requester DUT) and staged next values.
  logic [2:0]  vld [2];
  alu_op_e     op  [2][3];
  logic [31:0] a   [2][3];
  logic [31:0] b   [2][3];
  logic        rdy [2];

  logic [2:0]  svld [2];
  alu_op_e     sop  [2][3];
  logic [31:0] sa   [2][3];
  logic [31:0] sb   [2][3];
  logic        srdy [2];

  rsp_t expq [2][$];
  int   mptr [2];
  int   lastWin [2];
  int   nChecks = 0;
  int   nErrors = 0;

  assign if2.req_valid = vld[0][1:0];
  assign if2.rsp_ready = rdy[0];
  assign if3.req_valid = vld[1];
  assign if3.rsp_ready = rdy[1];

  for (genvar i = 0; i < 2; i++) begin : g_drv2
    assign if2.req_op[i] = op[0][i];
    assign if2.req_a[i]  = a[0][i];
    assign if2.req_b[i]  = b[0][i];
  end

  for (genvar i = 0; i < 3; i++) begin : g_drv3
    assign if3.req_op[i] = op[1][i];
    assign if3.req_a[i]  = a[1][i];
    assign if3.req_b[i]  = b[1][i];
  end

  function automatic logic [31:0] aluRef(alu_op_e o, logic [31:0] x, logic [31:0] y);
    logic [63:0] ext;
    int sh = int'(y[4:0]);
    case (o)
      ALU_ADD:  return x + y;
      ALU_SUB:  return x + ~y + 32'd1;
      ALU_AND:  return x & y;
      ALU_OR:   return x | y;
      ALU_XOR:  return x ^ y;
      ALU_SLT:  return (x[31] != y[31]) ? {31'b0, x[31]} : {31'b0, x < y};
      ALU_SLTU: return {31'b0, x < y};
      ALU_SLL:  return x << sh;
      ALU_SRL:  return x >> sh;
      ALU_SRA: begin
        ext = {{32{x[31]}}, x} >> sh;
        return ext[31:0];
      end
      default:  return 32'd0;
    endcase
  endfunction

  function automatic int pickWinner(logic [2:0] v, int n, int start);
    for (int k = 0; k < n; k++) begin
      if (v[(start + k) % n]) return (start + k) % n;
    end
    return -1;
  endfunction

  function automatic logic [2:0] getReady(int d);
    return (d == 0) ? {1'b0, if2.req_ready} : if3.req_ready;
  endfunction

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setReq(int d, int i, logic v, alu_op_e o, logic [31:0] x, logic [31:0] y);
    svld[d][i] = v;
    sop[d][i]  = o;
    sa[d][i]   = x;
    sb[d][i]   = y;
  endtask

  // Commit staged inputs at the falling edge, then predict the grant and enqueue the result.
  task automatic applyStimulus(int d);
    int n;
    int w;
    logic [2:0] expRdy;
    logic canAcc;
    @(negedge clk);
    vld[d] = svld[d];
    rdy[d] = srdy[d];
    for (int i = 0; i < 3; i++) begin
      op[d][i] = sop[d][i];
      a[d][i]  = sa[d][i];
      b[d][i]  = sb[d][i];
    end
    #2;
    n = (d == 0) ? 2 : 3;
    w = pickWinner(vld[d], n, mptr[d]);
    canAcc = (expq[d].size() == 0);
    expRdy = '0;
    if (w >= 0 && canAcc) expRdy[w] = 1'b1;
    checkOutput($sformatf("req_ready dut%0d", d), {29'b0, getReady(d)}, {29'b0, expRdy});
    lastWin[d] = -1;
    if (w >= 0 && canAcc) begin
      rsp_t e;
      e.id = w;
      e.op = op[d][w];
      e.y  = aluRef(op[d][w], a[d][w], b[d][w]);
      expq[d].push_back(e);
      mptr[d]    = (w + 1) % n;
      lastWin[d] = w;
    end
  endtask

  task automatic idle(int d);
    svld[d] = '0;
    srdy[d] = 1'b1;
    applyStimulus(d);
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst    = 1'b1;
    vld[0] = 3'b011;
    vld[1] = 3'b111;
    #2;
    checkOutput("req_ready dut0 in reset", {29'b0, getReady(0)}, 32'd0);
    checkOutput("req_ready dut1 in reset", {29'b0, getReady(1)}, 32'd0);
    for (int d = 0; d < 2; d++) begin
      expq[d].delete();
      mptr[d]    = 0;
      lastWin[d] = -1;
    end
    @(negedge clk);
    rst    = 1'b0;
    vld[0] = '0;
    vld[1] = '0;
    rdy[0] = 1'b1;
    rdy[1] = 1'b1;
    #1;
    checkOutput("rsp_y dut0 after reset", if2.rsp_y, 32'd0);
    checkOutput("rsp_id dut0 after reset", {31'b0, if2.rsp_id}, 32'd0);
    checkOutput("rsp_op dut0 after reset", {28'b0, if2.rsp_op}, {28'b0, ALU_ADD});
    checkOutput("rsp_y dut1 after reset", if3.rsp_y, 32'd0);
    checkOutput("rsp_id dut1 after reset", {30'b0, if3.rsp_id}, 32'd0);
    checkOutput("rsp_op dut1 after reset", {28'b0, if3.rsp_op}, {28'b0, ALU_ADD});
  endtask

  task automatic monitorRsp(int d, logic v, logic [2:0] id, logic [31:0] y, alu_op_e o, logic r);
    if (expq[d].size() == 0) begin
      checkOutput($sformatf("rsp_valid dut%0d idle", d), {31'b0, v}, 32'd0);
    end else begin
      rsp_t e;
      e = expq[d][0];
      checkOutput($sformatf("rsp_valid dut%0d", d), {31'b0, v}, 32'd1);
      checkOutput($sformatf("rsp_id dut%0d", d), {29'b0, id}, 32'(e.id));
      checkOutput($sformatf("rsp_y dut%0d", d), y, e.y);
      checkOutput($sformatf("rsp_op dut%0d", d), {28'b0, o}, {28'b0, e.op});
      if (r) void'(expq[d].pop_front());
    end
  endtask

  // Response monitors: one sample per cycle, between the falling edge and the grant check.
  always begin
    @(negedge clk);
    #1;
    if (!rst) monitorRsp(0, if2.rsp_valid, {2'b00, if2.rsp_id}, if2.rsp_y, if2.rsp_op, rdy[0]);
  end

  always begin
    @(negedge clk);
    #1;
    if (!rst) monitorRsp(1, if3.rsp_valid, {1'b0, if3.rsp_id}, if3.rsp_y, if3.rsp_op, rdy[1]);
  end

  task automatic singleOp(alu_op_e o, logic [31:0] x, logic [31:0] y, logic [31:0] ex, string name);
    setReq(0, 0, 1'b1, o, x, y);
    setReq(0, 1, 1'b0, ALU_ADD, 32'd0, 32'd0);
    srdy[0] = 1'b1;
    applyStimulus(0);
    idle(0);
    checkOutput(name, if2.rsp_y, ex);
  endtask

  task automatic randomCycle(int d);
    int n = (d == 0) ? 2 : 3;
    for (int i = 0; i < n; i++) begin
      if (svld[d][i] && lastWin[d] != i) begin
        if ($urandom_range(0, 7) == 0) svld[d][i] = 1'b0;
      end else begin
        svld[d][i] = ($urandom_range(0, 3) != 0);
        sop[d][i]  = alu_op_e'(4'($urandom_range(0, 11)));
        sa[d][i]   = randOperand();
        sb[d][i]   = randOperand();
      end
    end
    srdy[d] = ($urandom_range(0, 3) != 0);
    applyStimulus(d);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      vld[d] = '0; svld[d] = '0;
      rdy[d] = 1'b1; srdy[d] = 1'b1;
      mptr[d] = 0; lastWin[d] = -1;
      for (int i = 0; i < 3; i++) begin
        op[d][i] = ALU_ADD; sop[d][i] = ALU_ADD;
        a[d][i] = '0; sa[d][i] = '0;
        b[d][i] = '0; sb[d][i] = '0;
      end
    end

    applyReset();

    $display("[TB] single ADD");
    setReq(0, 0, 1'b1, ALU_ADD, 32'd5, 32'd7);
    setReq(0, 1, 1'b0, ALU_ADD, 32'd0, 32'd0);
    srdy[0] = 1'b1;
    applyStimulus(0);
    checkOutput("single add grant", {29'b0, getReady(0)}, 32'd1);
    idle(0);
    checkOutput("single add rsp_valid", {31'b0, if2.rsp_valid}, 32'd1);
    checkOutput("single add rsp_y", if2.rsp_y, 32'd12);

    $display("[TB] contention");
    applyReset();
    setReq(0, 0, 1'b1, ALU_ADD, 32'd10, 32'd20);
    setReq(0, 1, 1'b1, ALU_SUB, 32'd3, 32'd5);
    srdy[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0);
      checkOutput($sformatf("contention grant %0d", k), {29'b0, getReady(0)}, 32'(1 << (k % 2)));
    end
    idle(0);
    checkOutput("contention sub rsp_y", if2.rsp_y, 32'hFFFF_FFFE);
    checkOutput("contention sub rsp_id", {31'b0, if2.rsp_id}, 32'd1);

    $display("[TB] backpressure");
    setReq(0, 0, 1'b1, ALU_SRA, 32'h8000_0000, 32'd4);
    setReq(0, 1, 1'b0, ALU_ADD, 32'd0, 32'd0);
    srdy[0] = 1'b1;
    applyStimulus(0);
    setReq(0, 0, 1'b1, ALU_ADD, 32'd1, 32'd2);
    setReq(0, 1, 1'b1, ALU_XOR, 32'h0000_00FF, 32'h0000_000F);
    srdy[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0);
      checkOutput("backpressure ready", {29'b0, getReady(0)}, 32'd0);
      checkOutput("backpressure rsp_y held", if2.rsp_y, 32'hF800_0000);
    end
    srdy[0] = 1'b1;
    applyStimulus(0);
    checkOutput("drain+refill grant", {29'b0, getReady(0)}, 32'd2);
    idle(0);
    checkOutput("drain+refill rsp_valid", {31'b0, if2.rsp_valid}, 32'd1);
    checkOutput("drain+refill rsp_y", if2.rsp_y, 32'h0000_00F0);

    $display("[TB] compare and shift");
    singleOp(ALU_SLT,  32'hFFFF_FFFF, 32'd1,  32'd1, "slt -1<1");
    singleOp(ALU_SLTU, 32'hFFFF_FFFF, 32'd1,  32'd0, "sltu max<1");
    singleOp(ALU_SLL,  32'd1,         32'd33, 32'd2, "sll shamt mask");
    singleOp(alu_op_e'(4'd13), 32'hFFFF_FFFF, 32'd1, 32'd0, "undefined op");

    $display("[TB] reset mid-operation");
    setReq(0, 0, 1'b1, ALU_ADD, 32'd100, 32'd1);
    setReq(0, 1, 1'b1, ALU_OR, 32'h0000_00F0, 32'h0000_000F);
    srdy[0] = 1'b0;
    applyStimulus(0);
    applyStimulus(0);
    applyReset();
    srdy[0] = 1'b1;
    applyStimulus(0);
    checkOutput("first grant after reset", {29'b0, getReady(0)}, 32'd1);
    idle(0);
    idle(0);

    $display("[TB] NREQ=3 wrap");
    setReq(1, 0, 1'b0, ALU_ADD, 32'd0, 32'd0);
    setReq(1, 1, 1'b0, ALU_ADD, 32'd0, 32'd0);
    setReq(1, 2, 1'b1, ALU_ADD, 32'd2, 32'd3);
    srdy[1] = 1'b1;
    applyStimulus(1);
    checkOutput("wrap lone grant", {29'b0, getReady(1)}, 32'd4);
    setReq(1, 0, 1'b1, ALU_SUB, 32'd9, 32'd4);
    setReq(1, 1, 1'b1, ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("wrap grant %0d", k), {29'b0, getReady(1)}, 32'(1 << k));
    end
    idle(1);
    idle(1);

    $display("[TB] random traffic");
    for (int d = 0; d < 2; d++) begin
      svld[d] = '0;
      lastWin[d] = -1;
      repeat (400) randomCycle(d);
      idle(d);
      idle(d);
    end

    checkOutput("dut0 scoreboard drained", 32'(expq[0].size()), 32'd0);
    checkOutput("dut1 scoreboard drained", 32'(expq[1].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/rv32_alu_arb.md
# rv32_alu_arb

Round-robin arbiter and result stage that shares one `rv32_alu` instance between `NREQ` requesters. Candidates are the EX stage, the branch/address unit and a future CSR/atomic sequencer. Each requester presents an operation and operands on a valid/ready channel. One winner per cycle is granted and its operands are driven into the shared ALU. The result is registered and returned, tagged with the winner's index, on a single valid/ready response channel.

## Interface
- `NREQ`, default 2: number of requesters. Legal range 2..8.
- `IDW`, default `$clog2(NREQ)`: width of the requester index.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in `[NREQ]`: requester i has an operation pending.
- `req_ready` out `[NREQ]`: requester i is granted this cycle; the transfer completes on `req_valid[i] & req_ready[i]`.
- `req_op` in `[NREQ]` of `rv32_pkg::alu_op_e`: ALU operation per requester.
- `req_a` in `[NREQ][32]`: operand a per requester.
- `req_b` in `[NREQ][32]`: operand b per requester.
- `rsp_valid` out 1: the result register holds a result.
- `rsp_ready` in 1: the consumer accepts the result.
- `rsp_id` out `IDW`: index of the requester that produced the result.
- `rsp_y` out 32: ALU result.
- `rsp_op` out `alu_op_e`: operation echoed back, for consumer checking.

## Operation
- **ALU:** one internal `rv32_alu`. Its inputs are muxed from the granted requester.
  - ADD/SUB/AND/OR/XOR are modulo 2^32.
  - SLT/SLTU return 0 or 1.
  - Shifts use `b[4:0]` only. SRA is arithmetic.
  - Undefined op encodings return 0.
- **Accept condition:** `can_accept = !rsp_valid | rsp_ready`.
- **Arbitration:** round-robin pointer `ptr` (IDW bits).
  - The winner is the first i with `req_valid[i]` when scanning `ptr, ptr+1, … NREQ-1, 0, … ptr-1`.
  - `req_ready[winner] = can_accept`. All other `req_ready` bits are 0.
  - At most one `req_ready` bit is high in any cycle.
  - If no `req_valid` bit is high, all `req_ready` bits are 0 and `ptr` is unchanged.
- **Pointer update:** on a handshake with winner w, `ptr <= (w == NREQ-1) ? 0 : w+1`. There is no update without a handshake. A blocked cycle does not rotate priority.
- **Result register:**
  - On a handshake: load `rsp_y` with the ALU output, `rsp_id <= w`, `rsp_op <= req_op[w]`, and `rsp_valid <= 1`.
  - Else, if `rsp_valid & rsp_ready`: `rsp_valid <= 0`. The data fields hold their values.
- **Simultaneous drain and refill** (`rsp_valid & rsp_ready` plus a new handshake in the same cycle): load the new result; `rsp_valid` stays 1. This gives full throughput of one operation per cycle.
- **Backpressure** (`rsp_valid & !rsp_ready`): all `req_ready` bits are 0, and `rsp_y`, `rsp_id` and `rsp_op` are held stable.
- **Requester rules:** a requester must hold op and operands stable while `req_valid` is high and the request is not yet accepted. It may drop `req_valid` before acceptance, and is then simply not granted.
- **Reset:** an in-flight result is discarded and pending requests are ignored in the reset cycle. Reset values:
  - `rsp_valid = 0`
  - `rsp_id = 0`
  - `rsp_y = 0`
  - `rsp_op = ALU_ADD`
  - `ptr = 0`
  - all `req_ready = 0` (forced low while `rst` is high)

## Timing
- Latency is 1 cycle: a request accepted at edge N has its result visible with `rsp_valid` high after edge N, i.e. in cycle N+1.
- Throughput is one operation per cycle when `rsp_ready` is held high.
- `req_ready` is combinational from `req_valid`, `ptr`, `rsp_valid` and `rsp_ready`. There is no combinational path from `req_a`/`req_b` to any output.
- The critical path is operand mux into the ALU into the `rsp_y` flop. The block adds no other stages.
- Fairness: a continuously asserting requester is granted within NREQ handshakes.

## Test plan
- **Single ADD:** reset, then `req_valid[0]=1` with ADD a=5, b=7 and `rsp_ready=1`. Required: `req_ready[0]=1` in that cycle; the next cycle shows `rsp_valid=1`, `rsp_y=12`, `rsp_id=0`.
- **Round-robin, contention:** `req_valid=2'b11` held for 4 cycles with `rsp_ready=1`. Required: grants go 0,1,0,1; `rsp_id` follows 0,1,0,1 one cycle later; each accepted op's result matches it, e.g. SUB 3−5 = `0xFFFFFFFE`.
- **Backpressure:** `rsp_ready=0` while holding an SRA result of `0x80000000 >>> 4 = 0xF8000000`, with both requesters valid for 3 cycles. Required: all `req_ready=0`, `rsp_y` stable and `ptr` unchanged. Then raise `rsp_ready`: drain and new accept happen in the same cycle, and `rsp_valid` stays 1.
- **Compare and shift masking:** SLT a=`0xFFFFFFFF`, b=1 gives 1. SLTU with the same operands gives 0. SLL a=1, b=33 gives 2.
- **Reset mid-operation:** assert `rst` for 1 cycle while `rsp_valid=1` and requests are pending. Required next cycle: `rsp_valid=0`, `rsp_y=0`, and the first grant after reset goes to requester 0.
- **NREQ=3 wrap:** only requester 2 valid, one handshake, so `ptr` wraps to 0. Then all three valid: grant order is 0,1,2.
